// File: rtl/display_pkg.sv
// Shared types for the display block scanner.
// Block records, widths and scan FSM states.
package display_pkg;

    localparam int NUM_BLOCKS_DEF = 44;
    localparam int NAME_W         = 40;
    localparam int VALUE_W        = 32;
    localparam int NUM_W          = 6;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CAPT,
        SEND,
        NEXT
    } scan_state_t;

    typedef struct packed {
        logic               en;
        logic [NAME_W-1:0]  name;
        logic [VALUE_W-1:0] value;
    } blk_rec_t;

endpackage

// File: rtl/display_blk_cache.sv
// Copy of the last record accepted by the LCD writer for each block.
// The stale flag forces a full refresh after reset.
module display_blk_cache
    import display_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [NUM_W-1:0] i_widx,
    input  blk_rec_t         i_wdata,
    input  logic [NUM_W-1:0] i_ridx,
    output blk_rec_t         o_rdata,
    input  logic             i_clr_stale,
    output logic             o_stale
);

    localparam logic [NUM_W-1:0] LIMIT = NUM_W'(NUM_BLOCKS);

    blk_rec_t r_mem [NUM_BLOCKS];
    logic     r_stale;

    always_ff @(posedge clk) begin
        if (i_we && (i_widx < LIMIT))
            r_mem[i_widx] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_stale <= 1'b1;
        else if (i_clr_stale)
            r_stale <= 1'b0;
    end

    assign o_rdata = (i_ridx < LIMIT) ? r_mem[i_ridx] : '0;
    assign o_stale = r_stale;

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans display blocks, forwards changed ones to the LCD writer,
// and turns raw touch entries into one-cycle input pulses.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int RESP_LAT   = 1,
    parameter int SKIP_SAME  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scan_en,
    output logic [NUM_W-1:0]   display_number,
    input  logic               display_valid,
    input  logic [NAME_W-1:0]  display_name,
    input  logic [VALUE_W-1:0] display_value,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [NUM_W-1:0]   blk_index,
    output logic               blk_en,
    output logic [NAME_W-1:0]  blk_name,
    output logic [VALUE_W-1:0] blk_value,
    output logic               frame_done,
    input  logic               touch_valid,
    input  logic [VALUE_W-1:0] touch_value,
    output logic               input_valid,
    output logic [VALUE_W-1:0] input_value
);

    localparam logic [NUM_W-1:0] LAST    = NUM_W'(NUM_BLOCKS);
    localparam logic [7:0]       LAT_END = 8'(RESP_LAT - 1);

    scan_state_t        r_state;
    scan_state_t        w_next;
    logic [NUM_W-1:0]   r_num;
    logic [NUM_W-1:0]   r_blk_index;
    logic [7:0]         r_cnt;
    blk_rec_t           r_blk;
    logic               r_blk_valid;
    logic               r_frame_done;
    logic               r_input_valid;
    logic [VALUE_W-1:0] r_input_value;

    blk_rec_t w_cap;
    blk_rec_t w_cached;
    logic     w_stale;
    logic     w_fwd;
    logic     w_last;
    logic     w_we;
    logic     w_clr;

    assign w_cap  = {display_valid, display_name, display_value};
    assign w_last = (r_num == LAST);
    assign w_fwd  = (SKIP_SAME == 0) || w_stale
                 || (w_cap != w_cached);
    assign w_we   = (r_state == SEND) && blk_ready && !reset;
    assign w_clr  = (r_state == NEXT) && w_last;

    display_blk_cache #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_cache (
        .clk         (clk),
        .reset       (reset),
        .i_we        (w_we),
        .i_widx      (r_blk_index - 1'b1),
        .i_wdata     (r_blk),
        .i_ridx      (r_num - 1'b1),
        .o_rdata     (w_cached),
        .i_clr_stale (w_clr),
        .o_stale     (w_stale)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (scan_en) w_next = WAIT;
            WAIT: if (r_cnt == LAT_END) w_next = CAPT;
            CAPT: w_next = w_fwd ? SEND : NEXT;
            SEND: if (blk_ready) w_next = NEXT;
            NEXT: w_next = (w_last && !scan_en) ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num        <= '0;
            r_cnt        <= '0;
            r_blk        <= '0;
            r_blk_index  <= '0;
            r_blk_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (scan_en)
                        r_num <= 6'd1;
                end
                WAIT: r_cnt <= r_cnt + 8'd1;
                CAPT: begin
                    r_blk       <= w_cap;
                    r_blk_index <= r_num;
                    r_blk_valid <= w_fwd;
                end
                SEND: if (blk_ready) r_blk_valid <= 1'b0;
                NEXT: begin
                    r_cnt <= '0;
                    // A frame always runs to the last block before idling.
                    if (w_last) begin
                        r_frame_done <= 1'b1;
                        r_num        <= scan_en ? 6'd1 : 6'd0;
                    end else begin
                        r_num <= r_num + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_input_valid <= 1'b0;
            r_input_value <= '0;
        end else begin
            r_input_valid <= touch_valid;
            if (touch_valid)
                r_input_value <= touch_value;
        end
    end

    assign display_number = r_num;
    assign blk_valid      = r_blk_valid;
    assign blk_index      = r_blk_index;
    assign blk_en         = r_blk.en;
    assign blk_name       = r_blk.name;
    assign blk_value      = r_blk.value;
    assign frame_done     = r_frame_done;
    assign input_valid    = r_input_valid;
    assign input_value    = r_input_value;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-level
// model of which blocks must be forwarded.
module tb_display_scan_ctrl;

    localparam int NB = 44;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_en;
    logic [5:0]  display_number;
    logic        display_valid = 1'b0;
    logic [39:0] display_name = '0;
    logic [31:0] display_value = '0;
    logic        blk_valid;
    logic        blk_ready = 1'b1;
    logic [5:0]  blk_index;
    logic        blk_en;
    logic [39:0] blk_name;
    logic [31:0] blk_value;
    logic        frame_done;
    logic        touch_valid = 1'b0;
    logic [31:0] touch_value = '0;
    logic        input_valid;
    logic [31:0] input_value;

    display_scan_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .scan_en        (scan_en),
        .display_number (display_number),
        .display_valid  (display_valid),
        .display_name   (display_name),
        .display_value  (display_value),
        .blk_valid      (blk_valid),
        .blk_ready      (blk_ready),
        .blk_index      (blk_index),
        .blk_en         (blk_en),
        .blk_name       (blk_name),
        .blk_value      (blk_value),
        .frame_done     (frame_done),
        .touch_valid    (touch_valid),
        .touch_value    (touch_value),
        .input_valid    (input_valid),
        .input_value    (input_value)
    );

    always #5 clk = ~clk;

    logic        tb_en  [0:63];
    logic [39:0] tb_name[0:63];
    logic [31:0] tb_val [0:63];

    always @(posedge clk) begin
        if (display_number >= 6'd1 && display_number <= 6'(NB)) begin
            display_valid <= tb_en[display_number];
            display_name  <= tb_name[display_number];
            display_value <= tb_val[display_number];
        end else begin
            display_valid <= 1'b0;
            display_name  <= '0;
            display_value <= '0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [72:0] mc[0:63];
    bit          m_stale = 1'b1;
    logic [78:0] got[$];
    int          cyc = 0;
    int          last_fd = 0;
    bit          have_last = 1'b0;
    bit          dead = 1'b0;

    int          rdy_mode = 0;
    int          stall_idx = 0;
    int          stall_left = 0;
    int          vcnt = 0;
    int          tstep = 0;

    bit          pv = 1'b0;
    bit          pr = 1'b0;
    bit          prst = 1'b1;
    bit          pfd = 1'b0;
    bit          ptv = 1'b0;
    logic [78:0] pf = '0;
    logic [31:0] ptval = '0;
    logic [31:0] e_ival = '0;

    function automatic logic [72:0] tbl_rec(input int n);
        return {tb_en[n], tb_name[n], tb_val[n]};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (prst) begin
            chk("rst_out",
                {display_number, blk_valid, blk_index, blk_en,
                 blk_name, blk_value, frame_done, input_valid,
                 input_value}, '0);
            e_ival = '0;
        end else begin
            if (ptv)
                e_ival = ptval;
            chk("in_valid", input_valid, ptv);
            chk("in_value", input_value, e_ival);
            if (pv && !pr)
                chk("hold", {blk_valid, blk_index, blk_en, blk_name,
                             blk_value}, {1'b1, pf});
            else if (pv && pr)
                chk("drop", blk_valid, 0);
            if (blk_valid)
                chk("num_idx", display_number, blk_index);
            if (frame_done)
                chk("fd_pulse", pfd, 0);
        end
        if (stall_left > 0 && blk_valid && blk_index == 6'(stall_idx)) begin
            blk_ready = 1'b0;
            stall_left--;
        end else if (rdy_mode == 0) begin
            blk_ready = 1'b1;
        end else begin
            blk_ready = 1'($urandom_range(0, 1));
        end
        if (blk_valid && blk_index == 6'(stall_idx))
            vcnt++;
        if (blk_valid && blk_ready && !reset)
            got.push_back({blk_index, blk_en, blk_name, blk_value});
        if (reset) begin
            touch_valid = 1'b0;
        end else begin
            case (tstep)
                0: begin touch_valid = 1'b1; touch_value = 32'h10; end
                1: begin touch_valid = 1'b1; touch_value = 32'h20; end
                2, 3, 4: touch_valid = 1'b0;
                default: begin
                    touch_valid = ($urandom_range(0, 3) == 0);
                    touch_value = $urandom;
                end
            endcase
            tstep++;
        end
        pv    = blk_valid;
        pr    = blk_ready;
        prst  = reset;
        pfd   = frame_done;
        pf    = {blk_index, blk_en, blk_name, blk_value};
        ptv   = touch_valid;
        ptval = touch_value;
    end

    task automatic run_frame(input bit tied, input string tag);
        logic [78:0] exp[$];
        bit done;
        int n;
        if (dead) return;
        done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            chk({tag, "_timeout"}, 0, 1);
            dead = 1'b1;
            return;
        end
        for (int b = 1; b <= NB; b++)
            if (m_stale || tbl_rec(b) != mc[b])
                exp.push_back({6'(b), tbl_rec(b)});
        chk({tag, "_nrec"}, got.size(), exp.size());
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_rec"}, got[i], exp[i]);
        if (tied && have_last)
            chk({tag, "_period"}, cyc - last_fd, NB * 3 + got.size());
        foreach (got[i])
            mc[got[i][78:73]] = got[i][72:0];
        m_stale   = 1'b0;
        got.delete();
        last_fd   = cyc;
        have_last = 1'b1;
    endtask

    task automatic mutate(input int k);
        int n;
        for (int i = 0; i < k; i++) begin
            n = int'($urandom_range(1, NB));
            case ($urandom_range(0, 2))
                0: tb_en[n] = ~tb_en[n];
                1: tb_val[n] = $urandom;
                default: tb_name[n][7:0] = 8'($urandom_range(65, 90));
            endcase
        end
    endtask

    initial begin
        bit found;
        reset   = 1'b1;
        scan_en = 1'b0;
        for (int n = 0; n < 64; n++) begin
            tb_en[n]   = 1'b1;
            tb_val[n]  = 32'(n) * 32'h11111111;
            tb_name[n] = {"BLK", 8'(48 + n / 10), 8'(48 + n % 10)};
            mc[n]      = '0;
        end
        tb_name[18] = "REG05";

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_num", display_number, 0);
        scan_en = 1'b1;

        run_frame(1'b1, "f_full");
        run_frame(1'b1, "f_same");
        tb_val[18] = 32'hDEADBEEF;
        run_frame(1'b1, "f_one");

        tb_val[3]  = tb_val[3] ^ 32'h1;
        stall_idx  = 3;
        stall_left = 10;
        vcnt       = 0;
        run_frame(1'b0, "f_stall");
        chk("stall_len", vcnt, 11);
        stall_idx = 0;

        rdy_mode = 1;
        for (int f = 0; f < 5; f++) begin
            mutate(4);
            run_frame(1'b0, "f_rand");
        end

        mutate(3);
        repeat (60) @(posedge clk);
        #1 scan_en = 1'b0;
        run_frame(1'b0, "f_stop");
        have_last = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("stop_num", display_number, 0);
        chk("stop_valid", blk_valid, 0);

        rdy_mode   = 0;
        tb_val[20] = tb_val[20] ^ 32'h5;
        stall_idx  = 20;
        stall_left = 1000;
        scan_en    = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 2000 && !dead; i++) begin
            @(posedge clk);
            #1;
            if (blk_valid && blk_index == 6'd20) begin
                found = 1'b1;
                break;
            end
        end
        chk("send20_seen", found, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_num", display_number, 0);
        chk("rst_valid", blk_valid, 0);
        got.delete();
        m_stale    = 1'b1;
        stall_left = 0;
        stall_idx  = 0;
        have_last  = 1'b0;

        run_frame(1'b1, "f_restale");
        run_frame(1'b1, "f_quiet");
        scan_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Requester side of the 44-block touch-screen display interface.
- Steps display_number through blocks 1..NUM_BLOCKS and samples the registered display_valid/name/value answer from the CPU display block.
- Forwards changed blocks to the LCD writer over a valid/ready stream.
- Converts raw touch-keypad entries into the one-cycle input_valid/input_value pulse that the display block consumes.

Parameters:
- NUM_BLOCKS, 44: number of display blocks; indices 1..NUM_BLOCKS.
- RESP_LAT, 1: cycles from a display_number update until the answer is valid (the responder registers once).
- SKIP_SAME, 1: when 1, a block is suppressed if it equals the cached copy from the previous frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- scan_en  in  1  enables continuous frame scanning.
- display_number  out  6  block index requested from the responder; 0 when idle.
- display_valid  in  1  responder: block is in use.
- display_name  in  40  responder: 5 ASCII characters.
- display_value  in  32  responder: value to show.
- blk_valid  out  1  stream: block record available.
- blk_ready  in  1  stream: LCD writer accepts.
- blk_index  out  6  stream: block number.
- blk_en  out  1  stream: copy of display_valid (0 means clear the block).
- blk_name  out  40  stream: name.
- blk_value  out  32  stream: value.
- frame_done  out  1  one-cycle pulse when the last block of a frame is handled.
- touch_valid  in  1  raw touch entry strobe.
- touch_value  in  32  raw touch entry value.
- input_valid  out  1  one-cycle pulse to the display block.
- input_value  out  32  held value of the last entry.

Behaviour:
- Reset values:
  - display_number=0, blk_valid=0, blk_index=0, blk_en=0, blk_name=0, blk_value=0, frame_done=0, input_valid=0, input_value=0.
  - Cache is marked stale, so the first frame forwards every block.
  - FSM goes to IDLE.
- FSM states:
  - IDLE: display_number=0. If scan_en=1, load display_number=1 and go to WAIT.
  - WAIT: counter runs RESP_LAT cycles after display_number changes, then go to CAPT.
  - CAPT: latch {display_valid, display_name, display_value} into the blk_* registers and compare with cache[index].
    - Forward if SKIP_SAME=0, or the cache is stale, or the record differs. Then set blk_valid=1 and go to SEND.
    - Otherwise go to NEXT.
  - SEND: hold blk_* stable while blk_valid=1 and blk_ready=0. On blk_valid&blk_ready: write the cache, drop blk_valid, go to NEXT.
  - NEXT:
    - If index==NUM_BLOCKS: pulse frame_done, clear stale, display_number=1 if scan_en else 0; go to WAIT or IDLE respectively.
    - Otherwise display_number+1, go to WAIT.
- Latency: at least RESP_LAT+2 cycles per skipped block. A forwarded block adds at least 1 cycle for SEND.
- Cache: NUM_BLOCKS entries of 73 bits (en, name, value), indexed by block−1, written only on a completed handshake.
- Mid-frame scan_en=0: the current frame completes to NUM_BLOCKS, then the FSM goes to IDLE. A new frame always starts at block 1.
- Stream rules:
  - blk_valid never drops without blk_ready.
  - blk_* never change while blk_valid&!blk_ready.
  - At most one record is in flight.
- Input path, independent of the FSM:
  - On touch_valid: input_value<=touch_value, and input_valid=1 in the next cycle only.
  - Back-to-back strobes give back-to-back pulses, each with its own value.
  - input_value holds between strobes.
- Reset asserted mid-operation: all registers return to their reset values in that cycle. An in-flight record is abandoned and the cache goes stale.
- Width rule: display_number compares against NUM_BLOCKS at 6 bits. NUM_BLOCKS must be at most 63.

Decomposition:
- Shared package display_pkg:
  - NUM_BLOCKS_DEF=44, NAME_W=40, VALUE_W=32, NUM_W=6.
  - State encoding enum {IDLE, WAIT, CAPT, SEND, NEXT}.
  - Typedef blk_rec_t {en, name, value}.
- One sub-module: display_blk_cache, a NUM_BLOCKS×73 register array with one write port and one async read port, plus the stale flag.

Test Plan:
- Reset, then scan_en=1 with blk_ready tied 1 and the responder model answering block n with value n*0x11111111 → 44 records in order, blk_index 1..44, one frame_done pulse after index 44.
- Second frame with responder data unchanged and SKIP_SAME=1 → zero blk_valid; frame_done pulses again after 44*(RESP_LAT+2) cycles.
- Change only REG5 (block 18) to 0xDEADBEEF → exactly one record: blk_index=18, blk_value=0xDEADBEEF, name "REG05".
- blk_ready=0 for 10 cycles on block 3 → blk_valid stays high and blk_* stay stable; display_number stays 3; the record is accepted on the first ready cycle.
- touch_valid pulses with 0x00000010, then 0x00000020 on consecutive cycles → input_valid high for 2 consecutive cycles; input_value 0x10 then 0x20, held afterwards.
- Reset at block 20 during SEND → next cycle all outputs are 0 and display_number=0. On resume, the next frame forwards all 44 blocks (cache stale).
